spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master_if.sv | 33 +++
 rtl/spi_master.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/spi_master_if.sv
//==============================================================================
// Module      : spi_master_if
// Description : Control, data and serial-pin bundle between an SPI master and its user.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface spi_master_if #(
   parameter int N = 64
);
   logic         startIn;
   logic         abortIn;
   logic [N-1:0] dataIn;
   logic [N-1:0] dataOut;
   logic         doneOut;
   logic         busyOut;
   logic         ssOut;
   logic         sckOut;
   logic         mosiOut;
   logic         misoIn;

   modport master (
      input  startIn, abortIn, dataIn, misoIn,
      output dataOut, doneOut, busyOut, ssOut, sckOut, mosiOut
   );

   modport slave (
      output startIn, abortIn, dataIn, misoIn,
      input  dataOut, doneOut, busyOut, ssOut, sckOut, mosiOut
   );
endinterface

`default_nettype wire

// File: rtl/spi_master.sv
//==============================================================================
// Module      : spi_master
// Description : SPI mode-0 master, MSB first, one packet of PACKET_SIZE bytes per start.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_master #(
   parameter int PACKET_SIZE = 8,
   parameter int CLK_DIV     = 4
) (
   input  wire logic    clkIn,
   input  wire logic    nResetIn,
   spi_master_if.master bus
);

   localparam int             N        = PACKET_SIZE * 8;
   localparam int             BW       = $clog2(N);
   localparam logic [7:0]     c_RELOAD = 8'(CLK_DIV - 1);
   localparam logic [BW-1:0]  c_LAST   = BW'(N - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LEAD     = 3'd1,
      S_SHIFT_HI = 3'd2,
      S_SHIFT_LO = 3'd3,
      S_TRAIL    = 3'd4,
      S_GAP      = 3'd5
   } state_t;

   state_t        r_state, w_state;
   logic [7:0]    r_cnt,   w_cnt;
   logic [BW-1:0] r_bit,   w_bit;
   logic [N-1:0]  r_tx,    w_tx;
   logic [N-1:0]  r_rx,    w_rx;
   logic [N-1:0]  r_dout,  w_dout;
   logic          r_done,  w_done;
   logic          r_busy,  w_busy;
   logic          r_ss,    w_ss;
   logic          r_sck,   w_sck;
   logic          r_mosi,  w_mosi;

   logic w_tick;
   logic w_start;
   logic w_active;
   logic w_load;

   assign w_tick   = (r_cnt == 8'd0);
   assign w_start  = bus.startIn && !bus.abortIn;
   assign w_active = (r_state == S_LEAD) || (r_state == S_SHIFT_HI) ||
                     (r_state == S_SHIFT_LO) || (r_state == S_TRAIL);
   // A start is taken in IDLE or on the very edge GAP expires, so a held start
   // yields back-to-back packets with exactly CLK_DIV cycles of ss high.
   assign w_load   = w_start && ((r_state == S_IDLE) || ((r_state == S_GAP) && w_tick));

   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_bit   = r_bit;
      w_tx    = r_tx;
      w_rx    = r_rx;
      w_dout  = r_dout;
      w_done  = 1'b0;
      w_busy  = r_busy;
      w_ss    = r_ss;
      w_sck   = r_sck;
      w_mosi  = r_mosi;

      if (w_active && bus.abortIn) begin
         w_ss    = 1'b1;
         w_sck   = 1'b0;
         w_mosi  = 1'b0;
         w_cnt   = c_RELOAD;
         w_state = S_GAP;
      end else if (w_active && !w_tick) begin
         w_cnt = r_cnt - 8'd1;
      end else begin
         case (r_state)
            S_LEAD: begin
               w_sck   = 1'b1;
               w_cnt   = c_RELOAD;
               w_state = S_SHIFT_HI;
            end
            S_SHIFT_HI: begin
               w_sck = 1'b0;
               w_cnt = c_RELOAD;
               w_rx  = {r_rx[N-2:0], bus.misoIn};
               w_tx  = {r_tx[N-2:0], 1'b0};
               if (r_bit == c_LAST) begin
                  w_mosi  = 1'b0;
                  w_state = S_TRAIL;
               end else begin
                  w_mosi  = r_tx[N-2];
                  w_bit   = r_bit + 1'b1;
                  w_state = S_SHIFT_LO;
               end
            end
            S_SHIFT_LO: begin
               w_sck   = 1'b1;
               w_cnt   = c_RELOAD;
               w_state = S_SHIFT_HI;
            end
            S_TRAIL: begin
               w_ss    = 1'b1;
               w_dout  = r_rx;
               w_done  = 1'b1;
               w_cnt   = c_RELOAD;
               w_state = S_GAP;
            end
            S_GAP: begin
               if (w_tick) begin
                  w_busy  = 1'b0;
                  w_state = S_IDLE;
               end else begin
                  w_cnt = r_cnt - 8'd1;
               end
            end
            default: begin
               w_state = S_IDLE;
            end
         endcase
      end

      if (w_load) begin
         w_state = S_LEAD;
         w_cnt   = c_RELOAD;
         w_bit   = '0;
         w_tx    = bus.dataIn;
         w_ss    = 1'b0;
         w_busy  = 1'b1;
         w_mosi  = bus.dataIn[N-1];
      end
   end

   always_ff @(posedge clkIn) begin
      if (!nResetIn) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
         r_bit   <= '0;
         r_tx    <= '0;
         r_rx    <= '0;
         r_dout  <= '0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
         r_ss    <= 1'b1;
         r_sck   <= 1'b0;
         r_mosi  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_bit   <= w_bit;
         r_tx    <= w_tx;
         r_rx    <= w_rx;
         r_dout  <= w_dout;
         r_done  <= w_done;
         r_busy  <= w_busy;
         r_ss    <= w_ss;
         r_sck   <= w_sck;
         r_mosi  <= w_mosi;
      end
   end

   assign bus.dataOut = r_dout;
   assign bus.doneOut = r_done;
   assign bus.busyOut = r_busy;
   assign bus.ssOut   = r_ss;
   assign bus.sckOut  = r_sck;
   assign bus.mosiOut = r_mosi;

endmodule

`default_nettype wire
